// File: rtl/apb_master.sv
// Single-master APB bridge: turns host read/write requests into APB SETUP/ACCESS transfers.
// Optional macro APB_TIMEOUT_EN adds an ACCESS wait-state limit and the timeout_err output.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE_DATA,
  input  logic [ADDR_WIDTH-1:0] ahb_write_add,
  input  logic [DATA_WIDTH-1:0] ahb_write_data,
  input  logic [ADDR_WIDTH-1:0] ahb_read_add,
  output logic [DATA_WIDTH-1:0] ahb_read_data_out,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic                  PREADY
`ifdef APB_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic                    latch_s, rd_cap_s;
  logic                    psel_r, penable_r, pwrite_r;
  logic [ADDR_WIDTH-1:0]   paddr_r;
  logic [DATA_WIDTH-1:0]   pwdata_r, rdata_r;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        wait_cnt_r;
  logic                    tmo_s, timeout_err_r;
`endif

  // Next-state decode; latch_s marks every edge that enters SETUP with fresh request fields.
  always_comb begin
    state_s  = state_r;
    latch_s  = 1'b0;
    rd_cap_s = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (transfer) begin
          state_s = SETUP;
          latch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: state_s = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rd_cap_s = ~pwrite_r;
          if (transfer) begin
            state_s = SETUP;
            latch_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_s = IDLE;
          tmo_s   = 1'b1;
        end
`endif
        else begin
          state_s = ACCESS;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; PSEL/PENABLE are registered from the next state so they align with it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      psel_r    <= (state_s != IDLE);
      penable_r <= (state_s == ACCESS);
    end
  end

  // Request fields latched on SETUP entry; PWDATA keeps its old value across reads.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite_r <= 1'b0;
      paddr_r  <= {ADDR_WIDTH{1'b0}};
      pwdata_r <= {DATA_WIDTH{1'b0}};
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (latch_s) begin
        pwrite_r <= READ_WRITE_DATA;
        paddr_r  <= READ_WRITE_DATA ? ahb_write_add : ahb_read_add;
        if (READ_WRITE_DATA) begin
          pwdata_r <= ahb_write_data;
        end
      end
      if (rd_cap_s) begin
        rdata_r <= PRDATA;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  // Consecutive wait-state counter; restarts on every SETUP entry and after an abort.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= tmo_s;
      if (latch_s || tmo_s) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ACCESS) && !PREADY) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
    end
  end

  assign timeout_err = timeout_err_r;
`endif

  assign PSEL              = psel_r;
  assign PENABLE           = penable_r;
  assign PWRITE            = pwrite_r;
  assign PADDR             = paddr_r;
  assign PWDATA            = pwdata_r;
  assign ahb_read_data_out = rdata_r;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and randomized transfers against a transaction-level model.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          transfer;
  logic          READ_WRITE_DATA;
  logic [AW-1:0] ahb_write_add;
  logic [DW-1:0] ahb_write_data;
  logic [AW-1:0] ahb_read_add;
  logic [DW-1:0] ahb_read_data_out;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PSEL;
  logic          PENABLE;
  logic          PREADY;
`ifdef APB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction table and model state (last written data, last read data).
  logic          tx_wr    [64];
  logic [AW-1:0] tx_addr  [64];
  logic [DW-1:0] tx_wdata [64];
  logic [DW-1:0] tx_rdata [64];
  int            tx_waits [64];
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_rd;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
`ifdef APB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .transfer(transfer),
    .READ_WRITE_DATA(READ_WRITE_DATA),
    .ahb_write_add(ahb_write_add),
    .ahb_write_data(ahb_write_data),
    .ahb_read_add(ahb_read_add),
    .ahb_read_data_out(ahb_read_data_out),
    .PADDR(PADDR),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PREADY(PREADY)
`ifdef APB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  task automatic scramble();
    READ_WRITE_DATA = 1'($urandom);
    ahb_write_add   = $urandom;
    ahb_read_add    = $urandom;
    ahb_write_data  = $urandom;
  endtask

  task automatic apply(input int i);
    READ_WRITE_DATA = tx_wr[i];
    ahb_write_data  = tx_wr[i] ? tx_wdata[i] : $urandom;
    ahb_write_add   = tx_wr[i] ? tx_addr[i] : $urandom;
    ahb_read_add    = tx_wr[i] ? $urandom : tx_addr[i];
  endtask

  // Runs table entries 0..n-1 (back-to-back or with IDLE gaps) and checks every cycle against the model.
  task automatic test_transfers(input string name, input int n, input bit b2b);
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata;
    logic          s_pwrite;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || !b2b) begin
        apply(i);
        transfer = 1'b1;
      end
      @(posedge PCLK); #1;
      if (i > 0 && b2b) begin
        n_cmp++;
        if (ahb_read_data_out !== m_rd) begin
          n_bad++;
          $display("FAIL %s.rdout[%0d]: got %h expected %h", name, i - 1, ahb_read_data_out, m_rd);
        end
      end
      if (tx_wr[i]) m_pwdata = tx_wdata[i];
      n_cmp++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin
        n_bad++;
        $display("FAIL %s.setup[%0d]: got psel/penable %b%b expected 10", name, i, PSEL, PENABLE);
      end
      n_cmp++;
      if (PADDR !== tx_addr[i] || PWRITE !== tx_wr[i] || PWDATA !== m_pwdata) begin
        n_bad++;
        $display("FAIL %s.fields[%0d]: got %h/%b/%h expected %h/%b/%h", name, i,
                 PADDR, PWRITE, PWDATA, tx_addr[i], tx_wr[i], m_pwdata);
      end
      s_paddr  = PADDR;
      s_pwrite = PWRITE;
      s_pwdata = PWDATA;
      scramble();
      transfer = 1'($urandom);
      PREADY   = 1'($urandom);
      PRDATA   = $urandom;
      for (int k = 0; k <= tx_waits[i]; k++) begin
        @(posedge PCLK); #1;
        n_cmp++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== s_paddr ||
            PWRITE !== s_pwrite || PWDATA !== s_pwdata || ahb_read_data_out !== m_rd) begin
          n_bad++;
          $display("FAIL %s.access[%0d.%0d]: got %b%b %h/%b/%h rd %h expected 11 %h/%b/%h rd %h",
                   name, i, k, PSEL, PENABLE, PADDR, PWRITE, PWDATA, ahb_read_data_out,
                   s_paddr, s_pwrite, s_pwdata, m_rd);
        end
        PREADY = (k == tx_waits[i]);
        PRDATA = (k == tx_waits[i]) ? tx_rdata[i] : $urandom;
        if (k == tx_waits[i] && b2b && i < n - 1) begin
          apply(i + 1);
          transfer = 1'b1;
        end else begin
          scramble();
          transfer = (k == tx_waits[i]) ? 1'b0 : 1'($urandom);
        end
      end
      if (!tx_wr[i]) m_rd = tx_rdata[i];
      if (!b2b || i == n - 1) begin
        @(posedge PCLK); #1;
        n_cmp++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || ahb_read_data_out !== m_rd) begin
          n_bad++;
          $display("FAIL %s.idle[%0d]: got %b%b rd %h expected 00 rd %h", name, i,
                   PSEL, PENABLE, ahb_read_data_out, m_rd);
        end
        PREADY = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge PCLK); #1;
        end
      end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; transfer = 1'b0; READ_WRITE_DATA = 1'b0; PREADY = 1'b0;
    ahb_write_add = '0; ahb_write_data = '0; ahb_read_add = '0; PRDATA = '0;
    #1;
    n_cmp++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 32'h0 ||
        PWDATA !== 32'h0 || ahb_read_data_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: got %b%b%b %h %h %h expected all zero", PSEL, PENABLE, PWRITE,
               PADDR, PWDATA, ahb_read_data_out);
    end
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn  = 1'b1;
    m_pwdata = 32'h0;
    m_rd     = 32'h0;
    @(posedge PCLK); #1;
    n_cmp++;
    if (PSEL !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got psel %b expected 0", PSEL);
    end
  endtask

  task automatic test_write();
    tx_wr[0] = 1'b1; tx_addr[0] = 32'h00; tx_wdata[0] = 32'h45; tx_rdata[0] = $urandom; tx_waits[0] = 2;
    test_transfers("write", 1, 1'b0);
  endtask

  task automatic test_two_writes();
    tx_wr[0] = 1'b1; tx_addr[0] = 32'h04; tx_wdata[0] = 32'h55; tx_rdata[0] = $urandom; tx_waits[0] = 0;
    tx_wr[1] = 1'b1; tx_addr[1] = 32'h01; tx_wdata[1] = 32'h65; tx_rdata[1] = $urandom; tx_waits[1] = 1;
    test_transfers("two_writes", 2, 1'b0);
  endtask

  task automatic test_read();
    tx_wr[0] = 1'b0; tx_addr[0] = 32'h04; tx_wdata[0] = $urandom; tx_rdata[0] = 32'h55; tx_waits[0] = 2;
    test_transfers("read", 1, 1'b0);
    n_cmp++;
    if (ahb_read_data_out !== 32'h55) begin
      n_bad++;
      $display("FAIL read_value: got %h expected 00000055", ahb_read_data_out);
    end
  endtask

  task automatic test_back_to_back();
    tx_wr[0] = 1'b0; tx_addr[0] = 32'h01; tx_wdata[0] = $urandom; tx_rdata[0] = 32'h65; tx_waits[0] = 0;
    tx_wr[1] = 1'b0; tx_addr[1] = 32'h03; tx_wdata[1] = $urandom; tx_rdata[1] = $urandom; tx_waits[1] = 1;
    tx_wr[2] = 1'b1; tx_addr[2] = $urandom; tx_wdata[2] = $urandom; tx_rdata[2] = $urandom; tx_waits[2] = 0;
    tx_wr[3] = 1'b0; tx_addr[3] = $urandom; tx_wdata[3] = $urandom; tx_rdata[3] = $urandom; tx_waits[3] = 2;
    test_transfers("back_to_back", 4, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        tx_wr[i]    = 1'($urandom);
        tx_addr[i]  = $urandom;
        tx_wdata[i] = $urandom;
        tx_rdata[i] = $urandom;
        tx_waits[i] = $urandom_range(0, 3);
      end
      test_transfers("random", 16, 1'(r));
    end
  endtask

  task automatic test_reset_mid();
    READ_WRITE_DATA = 1'b0;
    ahb_read_add    = 32'hA5A5_0010;
    transfer        = 1'b1;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    PREADY   = 1'b0;
    @(posedge PCLK); #1;
    n_cmp++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_access: got %b%b expected 11", PSEL, PENABLE);
    end
    PREADY = 1'b1;
    PRDATA = 32'hDEAD_BEEF;
    #2;
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 32'h0 ||
        PWDATA !== 32'h0 || ahb_read_data_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got %b%b%b %h %h %h expected all zero", PSEL, PENABLE, PWRITE,
               PADDR, PWDATA, ahb_read_data_out);
    end
    @(posedge PCLK); #1;
    PRESETn  = 1'b1;
    PREADY   = 1'b0;
    m_pwdata = 32'h0;
    m_rd     = 32'h0;
    @(posedge PCLK); #1;
    n_cmp++;
    if (PSEL !== 1'b0 || ahb_read_data_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_after: got psel %b rd %h expected 0 0", PSEL, ahb_read_data_out);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    READ_WRITE_DATA = 1'b0;
    ahb_read_add    = $urandom;
    transfer        = 1'b1;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    PREADY   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK); #1;
      n_cmp++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || timeout_err !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_wait[%0d]: got %b%b err %b expected 11 err 0", k, PSEL, PENABLE, timeout_err);
      end
      PRDATA = $urandom;
    end
    @(posedge PCLK); #1;
    n_cmp++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || timeout_err !== 1'b1 || ahb_read_data_out !== m_rd) begin
      n_bad++;
      $display("FAIL timeout_abort: got %b%b err %b rd %h expected 00 err 1 rd %h",
               PSEL, PENABLE, timeout_err, ahb_read_data_out, m_rd);
    end
    @(posedge PCLK); #1;
    n_cmp++;
    if (timeout_err !== 1'b0 || PSEL !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got err %b psel %b expected 0 0", timeout_err, PSEL);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_two_writes();
    test_read();
    test_back_to_back();
    test_random();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-master AMBA APB bridge; converts a simple request interface (host side, ahb_* signals) into APB SETUP/ACCESS transfers to one slave.
- Sits between the host-side bus logic and the APB peripheral fabric.
- Each transfer is a single read or a single write; completion is gated by PREADY; read data is returned on ahb_read_data_out.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait states before abort; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; all logic is rising-edge.
- PRESETn  in  1  asynchronous active-low reset.
- transfer  in  1  request; 1 = start or continue transfers.
- READ_WRITE_DATA  in  1  direction; 1 = write, 0 = read.
- ahb_write_add  in  ADDR_WIDTH  write address.
- ahb_write_data  in  DATA_WIDTH  write data.
- ahb_read_add  in  ADDR_WIDTH  read address.
- ahb_read_data_out  out  DATA_WIDTH  last completed read data.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PSEL  out  1  APB slave select.
- PENABLE  out  1  APB enable.
- PREADY  in  1  APB slave ready.
- Interface: one clock (PCLK); reset PRESETn is asynchronous and active-low.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - FSM goes to IDLE.
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA, ahb_read_data_out = 0.
  - Reset mid-transfer aborts the transfer immediately; no read data is captured.
- FSM states: IDLE, SETUP, ACCESS (state register clocked; PSEL/PENABLE decoded from state).
- IDLE:
  - PSEL=0, PENABLE=0.
  - If transfer=1 at a clock edge: go to SETUP and latch the transfer fields.
    - PWRITE <= READ_WRITE_DATA.
    - PADDR <= write ? ahb_write_add : ahb_read_add.
    - PWDATA <= ahb_write_data on a write; PWDATA holds its previous value on a read.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Always goes to ACCESS after exactly one cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR/PWRITE/PWDATA are held stable.
  - PREADY=0: stay in ACCESS (wait state); no limit unless APB_TIMEOUT_EN.
  - PREADY=1 at an edge (transfer completes):
    - On a read, ahb_read_data_out <= PRDATA.
    - If transfer=1: go to SETUP and latch new fields (back-to-back; no IDLE cycle).
    - Otherwise: go to IDLE.
- Minimum transfer length: 2 cycles (SETUP plus one ACCESS).
- ahb_read_data_out holds its value until the next completed read; writes never change it.
- transfer and PREADY sampled together at completion: PREADY takes effect; transfer only selects the next state.
- PADDR/PWDATA/PWRITE retain their last values in IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_err (1 bit, reset 0).
  - A counter runs while in ACCESS with PREADY=0.
  - After TIMEOUT_CYCLES consecutive wait states: the FSM aborts to IDLE, timeout_err pulses high for one cycle, and ahb_read_data_out is unchanged.
  - The counter clears on entry to SETUP.
- Undefined: no timeout_err port and no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write 0x45 to 0x00: transfer=1 with READ_WRITE_DATA=1; PREADY=1 on the third ACCESS cycle; transfer=0 -> PSEL/PENABLE=1/0 then 1/1, PADDR=0x00, PWDATA=0x45, PWRITE=1; IDLE after PREADY.
- Writes 0x55 to 0x04, then 0x65 to 0x01 -> PADDR/PWDATA match each request; PSEL deasserts between them.
- Read 0x04 with PRDATA=0x55 at PREADY -> PWRITE=0, PADDR=0x04, ahb_read_data_out=0x55 after the completion edge; PRDATA changes during wait states are ignored.
- Back-to-back transfers: transfer held 1 across PREADY -> the next SETUP follows the completing ACCESS directly; read 0x01 (0x65) then 0x03 -> outputs update per transfer.
- Reset mid-transfer: PRESETn=0 while in ACCESS -> PSEL=PENABLE=0 and all outputs 0 immediately, without waiting for a clock edge.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY held 0 -> IDLE after 4 wait states; timeout_err high for one cycle; ahb_read_data_out unchanged.
